// File: rtl/vend_select_ctrl_pkg.sv
// Shared definitions for the vending selection controller.
// Contents: FSM state encoding, coin codes with their credit-value decode,
// and the common widths (credit, row address, number of rows).
package vend_pkg;

  localparam int CREDIT_W = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_ROWS = 8;
  localparam int STOCK_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } coin_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input coin_t code);
    case (code)
      COIN_1:  return 8'd1;
      COIN_2:  return 8'd2;
      COIN_5:  return 8'd5;
      default: return 8'd10;
    endcase
  endfunction

endpackage

// File: rtl/vend_select_ctrl_if.sv
// Bus bundle between the vending front panel / supervisor and the
// selection controller.
//   master: drives coin/selection/cancel/restock strobes, observes results
//   slave : the controller (vend_select_ctrl)
interface vend_select_ctrl_if;
  import vend_pkg::*;

  logic                coin_valid;
  logic [1:0]          coin_code;
  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic                cancel;
  logic                restock_valid;
  logic [ADDR_W-1:0]   restock_addr;

  logic [ADDR_W-1:0]   addr;
  logic                row_en;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic                sold_out;
  logic                low_credit;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic                coin_reject;

  modport master (
    output coin_valid, coin_code, sel_valid, sel_addr, cancel,
           restock_valid, restock_addr,
    input  addr, row_en, busy, credit, sold_out, low_credit,
           change_valid, change_amount, coin_reject
  );

  modport slave (
    input  coin_valid, coin_code, sel_valid, sel_addr, cancel,
           restock_valid, restock_addr,
    output addr, row_en, busy, credit, sold_out, low_credit,
           change_valid, change_amount, coin_reject
  );

endinterface

// File: rtl/vend_select_ctrl_stock.sv
// vend_stock_bank: eight 4-bit per-row stock counters.
// Ports:
//   clk, rst_n            clock, async active-low reset (loads STOCK_INIT)
//   i_rd_addr / o_rd_data combinational read of one row
//   i_dec_en / i_dec_addr decrement one row (caller guarantees count > 0)
//   i_restock_en / _addr  reload one row to STOCK_INIT
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int STOCK_INIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [STOCK_W-1:0] o_rd_data,
  input  logic               i_dec_en,
  input  logic [ADDR_W-1:0]  i_dec_addr,
  input  logic               i_restock_en,
  input  logic [ADDR_W-1:0]  i_restock_addr
);

  logic [STOCK_W-1:0] r_stock [NUM_ROWS];

  assign o_rd_data = r_stock[i_rd_addr];

  // Restock happens only in IDLE and decrement only in CHECK, so the two
  // writes never collide on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      if (i_restock_en) r_stock[i_restock_addr] <= STOCK_W'(STOCK_INIT);
      if (i_dec_en)     r_stock[i_dec_addr]     <= r_stock[i_dec_addr] - 1'b1;
    end
  end

endmodule

// File: rtl/vend_select_ctrl.sv
// vend_select_ctrl: vending transaction controller feeding the 3-to-8 row
// decoder. Accumulates coin credit, latches a selection, checks stock and
// credit, holds row_en for DISPENSE_CYCLES and then returns change.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus (slave) coin/selection/cancel/restock strobes in; row address,
//               row enable, busy, credit and result pulses out (all registered)
module vend_select_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE           = 15,
  parameter int STOCK_INIT      = 2,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CREDIT_MAX      = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  vend_select_ctrl_if.slave bus
);

  localparam logic [7:0] CNT_LOAD = 8'(DISPENSE_CYCLES - 1);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic                r_row_en, w_row_en_nxt;
  logic                r_busy;
  logic                r_sold_out, w_sold_out_nxt;
  logic                r_low_credit, w_low_credit_nxt;
  logic                r_change_valid, w_change_valid_nxt;
  logic [CREDIT_W-1:0] r_change_amount, w_change_amount_nxt;
  logic                r_coin_reject, w_coin_reject_nxt;
  logic                w_dec_en, w_restock_en;
  logic [STOCK_W-1:0]  w_stock_rd;

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > (CREDIT_W+1)'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX) : sum[CREDIT_W-1:0];
  endfunction

  vend_stock_bank #(.STOCK_INIT(STOCK_INIT)) u_stock (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rd_addr     (r_addr),
    .o_rd_data     (w_stock_rd),
    .i_dec_en      (w_dec_en),
    .i_dec_addr    (r_addr),
    .i_restock_en  (w_restock_en),
    .i_restock_addr(bus.restock_addr)
  );

  always_comb begin
    w_state_nxt         = r_state;
    w_credit_nxt        = r_credit;
    w_addr_nxt          = r_addr;
    w_cnt_nxt           = r_cnt;
    w_row_en_nxt        = 1'b0;
    w_sold_out_nxt      = 1'b0;
    w_low_credit_nxt    = 1'b0;
    w_change_valid_nxt  = 1'b0;
    w_change_amount_nxt = '0;
    w_coin_reject_nxt   = bus.coin_valid && (r_state != ST_IDLE);
    w_dec_en            = 1'b0;
    w_restock_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_restock_en = bus.restock_valid;
        if (bus.coin_valid)
          w_credit_nxt = sat_add(r_credit, coin_value(coin_t'(bus.coin_code)));
        // Cancel blocks a same-cycle selection even when there is nothing to refund.
        if (bus.cancel) begin
          if (r_credit != '0) w_state_nxt = ST_CHANGE;
        end else if (bus.sel_valid) begin
          w_addr_nxt  = bus.sel_addr;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (w_stock_rd == '0) begin
          w_sold_out_nxt = 1'b1;
        end else if (r_credit < CREDIT_W'(PRICE)) begin
          w_low_credit_nxt = 1'b1;
        end else begin
          w_credit_nxt = r_credit - CREDIT_W'(PRICE);
          w_dec_en     = 1'b1;
          w_cnt_nxt    = CNT_LOAD;
          w_row_en_nxt = 1'b1;
          w_state_nxt  = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        // row_en was raised on entry; keep it for the remaining count.
        if (r_cnt == '0) begin
          w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end else begin
          w_cnt_nxt    = r_cnt - 1'b1;
          w_row_en_nxt = 1'b1;
        end
      end
      ST_CHANGE: begin
        w_change_valid_nxt  = 1'b1;
        w_change_amount_nxt = r_credit;
        w_credit_nxt        = '0;
        w_state_nxt         = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_credit        <= '0;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_row_en        <= 1'b0;
      r_busy          <= 1'b0;
      r_sold_out      <= 1'b0;
      r_low_credit    <= 1'b0;
      r_change_valid  <= 1'b0;
      r_change_amount <= '0;
      r_coin_reject   <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_credit        <= w_credit_nxt;
      r_addr          <= w_addr_nxt;
      r_cnt           <= w_cnt_nxt;
      r_row_en        <= w_row_en_nxt;
      r_busy          <= (w_state_nxt != ST_IDLE);
      r_sold_out      <= w_sold_out_nxt;
      r_low_credit    <= w_low_credit_nxt;
      r_change_valid  <= w_change_valid_nxt;
      r_change_amount <= w_change_amount_nxt;
      r_coin_reject   <= w_coin_reject_nxt;
    end
  end

  assign bus.addr          = r_addr;
  assign bus.row_en        = r_row_en;
  assign bus.busy          = r_busy;
  assign bus.credit        = r_credit;
  assign bus.sold_out      = r_sold_out;
  assign bus.low_credit    = r_low_credit;
  assign bus.change_valid  = r_change_valid;
  assign bus.change_amount = r_change_amount;
  assign bus.coin_reject   = r_coin_reject;

endmodule

// File: tb/tb_vend_select_ctrl.sv
module tb_vend_select_ctrl;
  localparam int PRICE = 15;
  localparam int STOCK_INIT = 2;
  localparam int DISP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vend_select_ctrl_if bus ();

  vend_select_ctrl #(.PRICE(PRICE), .STOCK_INIT(STOCK_INIT),
                     .DISPENSE_CYCLES(DISP), .CREDIT_MAX(255)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Output word: {row_en,busy,sold_out,low_credit,change_valid,coin_reject,addr,credit,change_amount}
  function automatic logic [24:0] pack(input bit row, input bit bsy, input bit sold,
                                       input bit low, input bit chg, input bit rej,
                                       input int ad, input int cr, input int am);
    return {row, bsy, sold, low, chg, rej, 3'(ad), 8'(cr), 8'(am)};
  endfunction

  function automatic logic [24:0] actual();
    return {bus.row_en, bus.busy, bus.sold_out, bus.low_credit, bus.change_valid,
            bus.coin_reject, bus.addr, bus.credit, bus.change_amount};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h (row,busy,sold,low,chg,rej=%b addr=%0d credit=%0d amt=%0d) want %h",
               name, act, act[24:19], act[18:16], act[15:8], act[7:0], exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic step(input bit cv, input bit [1:0] cc, input bit sv, input bit [2:0] sa,
                      input bit ca, input bit rv, input bit [2:0] ra);
    bus.coin_valid = cv; bus.coin_code = cc; bus.sel_valid = sv; bus.sel_addr = sa;
    bus.cancel = ca; bus.restock_valid = rv; bus.restock_addr = ra;
    @(posedge clk);
    #1;
    bus.coin_valid = 0; bus.sel_valid = 0; bus.cancel = 0; bus.restock_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.coin_valid = 0; bus.coin_code = 0; bus.sel_valid = 0; bus.sel_addr = 0;
    bus.cancel = 0; bus.restock_valid = 0; bus.restock_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Select a row and follow the transaction until busy falls (bounded).
  task automatic vend(input bit [2:0] row, output int n_row, output bit sold, output bit low);
    n_row = 0; sold = 0; low = 0;
    step(0, 0, 1, row, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (bus.row_en) n_row++;
      if (bus.sold_out) sold = 1;
      if (bus.low_credit) low = 1;
      if (!bus.busy) return;
    end
    check_int("vend_timeout", 1, 0);
  endtask

  // ---------------- reference model ----------------
  int m_credit, m_addr;
  int m_stock[8];
  logic [24:0] mq[$];
  int coin_val[4] = '{1, 2, 5, 10};

  task automatic model_reset();
    m_credit = 0; m_addr = 0; mq.delete();
    for (int i = 0; i < 8; i++) m_stock[i] = STOCK_INIT;
  endtask

  // Pending future outputs live in mq; while any are pending the machine is busy
  // and the inputs of that cycle are ignored apart from coin rejection.
  task automatic model_step(input bit cv, input bit [1:0] cc, input bit sv, input bit [2:0] sa,
                            input bit ca, input bit rv, input bit [2:0] ra,
                            output logic [24:0] e);
    int pre;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      if (cv) e = e | pack(0, 0, 0, 0, 0, 1, 0, 0, 0);
      return;
    end
    if (rv) m_stock[ra] = STOCK_INIT;
    pre = m_credit;
    if (cv) m_credit = (m_credit + coin_val[cc] > 255) ? 255 : m_credit + coin_val[cc];
    if (ca) begin
      if (pre > 0) begin
        e = pack(0, 1, 0, 0, 0, 0, m_addr, m_credit, 0);
        mq.push_back(pack(0, 0, 0, 0, 1, 0, m_addr, 0, m_credit));
        m_credit = 0;
      end else begin
        e = pack(0, 0, 0, 0, 0, 0, m_addr, m_credit, 0);
      end
    end else if (sv) begin
      m_addr = sa;
      e = pack(0, 1, 0, 0, 0, 0, m_addr, m_credit, 0);
      if (m_stock[sa] == 0) begin
        mq.push_back(pack(0, 0, 1, 0, 0, 0, m_addr, m_credit, 0));
      end else if (m_credit < PRICE) begin
        mq.push_back(pack(0, 0, 0, 1, 0, 0, m_addr, m_credit, 0));
      end else begin
        m_credit -= PRICE;
        m_stock[sa]--;
        repeat (DISP) mq.push_back(pack(1, 1, 0, 0, 0, 0, m_addr, m_credit, 0));
        if (m_credit > 0) begin
          mq.push_back(pack(0, 1, 0, 0, 0, 0, m_addr, m_credit, 0));
          mq.push_back(pack(0, 0, 0, 0, 1, 0, m_addr, 0, m_credit));
          m_credit = 0;
        end else begin
          mq.push_back(pack(0, 0, 0, 0, 0, 0, m_addr, 0, 0));
        end
      end
    end else begin
      e = pack(0, 0, 0, 0, 0, 0, m_addr, m_credit, 0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          cv;
    bit [1:0]    cc;
    bit          sv;
    bit [2:0]    sa;
    bit          ca;
    logic [24:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit cv, input bit [1:0] cc, input bit sv, input bit [2:0] sa,
                     input bit ca, input bit row, input bit bsy, input bit sold,
                     input bit low, input bit chg, input bit rej,
                     input int ad, input int cr, input int am);
    vec_t v;
    v.cv = cv; v.cc = cc; v.sv = sv; v.sa = sa; v.ca = ca;
    v.exp = pack(row, bsy, sold, low, chg, rej, ad, cr, am);
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_row;
    bit sold, low;
    logic [24:0] e;
    bit cv, sv, ca, rv;
    bit [1:0] cc;
    bit [2:0] sa, ra;
    int r;

    // coins 10+5, vend row 3, no change
    add(1, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 10, 0);
    add(1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 15, 0);
    add(0, 0, 1, 3, 0,  0, 1, 0, 0, 0, 0, 3, 15, 0);
    repeat (4) add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0, 0);
    // coins 10+10, vend row 0, change 5
    add(1, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 10, 0);
    add(1, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 20, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 20, 0);
    repeat (4) add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 5);
    // credit 5, select row 1 -> low_credit, then cancel -> refund 5
    add(1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5, 0);
    add(0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 5, 0);
    add(0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1, 5, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1, 0, 5);
    // credit 5, coin 10 with sel row 2 same cycle, coin during dispense rejected
    add(1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 5, 0);
    add(1, 3, 1, 2, 0,  0, 1, 0, 0, 0, 0, 2, 15, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0, 0);

    bus.coin_valid = 0; bus.coin_code = 0; bus.sel_valid = 0; bus.sel_addr = 0;
    bus.cancel = 0; bus.restock_valid = 0; bus.restock_addr = 0;
    #2;
    check("reset_state", actual(), '0);
    do_reset();
    check("after_reset_release", actual(), '0);

    foreach (tbl[i]) begin
      step(tbl[i].cv, tbl[i].cc, tbl[i].sv, tbl[i].sa, tbl[i].ca, 0, 0);
      check($sformatf("table_row_%0d", i), actual(), tbl[i].exp);
    end

    // row 7: two vends, then sold out with credit kept, restock, vend again
    for (int k = 0; k < 2; k++) begin
      step(1, 3, 0, 0, 0, 0, 0);
      step(1, 2, 0, 0, 0, 0, 0);
      vend(7, n_row, sold, low);
      check_int("row7_vend_row_en_cycles", n_row, DISP);
      check_int("row7_vend_credit", bus.credit, 0);
    end
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    vend(7, n_row, sold, low);
    check_int("row7_sold_out_pulse", sold, 1);
    check_int("row7_sold_out_no_row_en", n_row, 0);
    check_int("row7_sold_out_credit_kept", bus.credit, 15);
    step(0, 0, 0, 0, 0, 0, 0);
    check_int("sold_out_one_cycle", bus.sold_out, 0);
    step(0, 0, 0, 0, 0, 1, 7);
    vend(7, n_row, sold, low);
    check_int("row7_restocked_vend", n_row, DISP);
    check_int("row7_restocked_credit", bus.credit, 0);

    // reset in the middle of a dispense
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_int("pre_reset_row_en", bus.row_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_dispense", actual(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    // row 0 was vended once before reset; two more vends prove it reloaded to 2
    for (int k = 0; k < 2; k++) begin
      step(1, 3, 0, 0, 0, 0, 0);
      step(1, 2, 0, 0, 0, 0, 0);
      vend(0, n_row, sold, low);
      check_int("row0_after_reset_vend", n_row, DISP);
    end
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    vend(0, n_row, sold, low);
    check_int("row0_after_reset_sold_out", sold, 1);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      cv = (r < 40); ca = (r >= 40 && r < 45); sv = (r >= 45 && r < 58);
      cc = 2'($urandom_range(0, 3));
      sa = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 99) < 3);
      ra = 3'($urandom_range(0, 7));
      model_step(cv, cc, sv, sa, ca, rv, ra, e);
      step(cv, cc, sv, sa, ca, rv, ra);
      check($sformatf("random_cycle_%0d", c), actual(), e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
